// File: rtl/neuron_pkg.sv
// Shared types and helpers for the multi-lane neuron: FSM states, activation
// mode encodings, beat-count helper and a saturating signed adder.
package neuron_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, ACT, OUT} state_t;

  localparam logic ACT_RELU   = 1'b0;
  localparam logic ACT_LINEAR = 1'b1;

  function automatic int calc_beats(input int num, input int lanes);
    return (num + lanes - 1) / lanes;
  endfunction

  // Adds in 64 bits and clamps to the signed range of 'width' bits (width <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/neuron_wmem.sv
// Weight store: sequential single-weight write with wrapping pointer, and a
// registered LANES-wide row read per beat index (lanes past the end read as 0).
module neuron_wmem
  import neuron_pkg::*;
#(
  parameter int NUM_WEIGHT = 784,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  localparam int BEATS     = calc_beats(NUM_WEIGHT, LANES),
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_dat,
  input  logic [BW-1:0]               rd_beat,
  output logic [LANES*DATA_WIDTH-1:0] rd_row
);

  localparam int PW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;

  logic [DATA_WIDTH-1:0]       mem [NUM_WEIGHT];
  logic [PW-1:0]               wptr;
  logic [LANES*DATA_WIDTH-1:0] row_nxt;
  logic [31:0]                 idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
    end else if (wr_en) begin
      wptr <= (wptr == PW'(NUM_WEIGHT - 1)) ? '0 : wptr + 1'b1;
    end
  end

  // Array contents are deliberately left out of reset so weights survive it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_dat;
  end

  always_comb begin
    row_nxt = '0;
    idx     = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = 32'(rd_beat) * 32'(LANES) + 32'(k);
      if (idx < 32'(NUM_WEIGHT)) row_nxt[k*DATA_WIDTH +: DATA_WIDTH] = mem[idx[PW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    rd_row <= row_nxt;
  end

endmodule

// File: rtl/neuron_mac_lanes.sv
// Multi-lane fully-connected neuron: saturating MAC over LANES inputs per beat,
// bias add, ReLU/linear activation; result 6 cycles after last beat, held until out_ready.
module neuron_mac_lanes
  import neuron_pkg::*;
#(
  parameter int LAYER_NO         = 1,
  parameter int NEURON_NO        = 0,
  parameter int NUM_WEIGHT       = 784,
  parameter int DATA_WIDTH       = 16,
  parameter int LANES            = 4,
  parameter int WEIGHT_INT_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        weight_valid,
  input  logic [31:0]                 weight_value,
  input  logic                        bias_valid,
  input  logic [31:0]                 bias_value,
  input  logic [31:0]                 config_layer_num,
  input  logic [31:0]                 config_neuron_num,
  input  logic                        act_mode,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = 2 * DW;
  localparam int TW    = AW + $clog2(LANES);
  localparam int WI    = WEIGHT_INT_WIDTH;
  localparam int BEATS = calc_beats(NUM_WEIGHT, LANES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t state_q, state_d;

  logic                  cfg_match, accept, last_beat, pipe_empty, done;
  logic [BW-1:0]         beat_q, s0_beat;
  logic                  s0_vld, s1_vld, s2_vld;
  logic [LANES*DW-1:0]   s0_dat, s1_dat, row;
  logic signed [AW-1:0]  prod [LANES];
  logic signed [TW-1:0]  tree;
  logic signed [AW-1:0]  acc_q, bias_term;
  logic signed [63:0]    acc_add, acc_sum;
  logic [DW-1:0]         bias_q, act_f, act_res;
  logic [WI-1:0]         act_u;
  logic                  act_sign_ok;
  logic                  unused_bits;

  assign cfg_match  = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
  assign accept     = in_valid & in_ready;
  assign last_beat  = (beat_q == BW'(BEATS - 1));
  assign pipe_empty = ~(s0_vld | s1_vld | s2_vld);
  assign done       = (state_q == OUT) & out_ready;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = last_beat ? DRAIN : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_d = DRAIN;
      end
      DRAIN:   if (pipe_empty) state_d = BIAS;
      BIAS:    state_d = ACT;
      ACT:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q  <= '0;
      s0_beat <= '0;
      s0_vld  <= 1'b0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
    end else begin
      s0_vld <= accept;
      s1_vld <= s0_vld;
      s2_vld <= s1_vld;
      if (accept) begin
        s0_beat <= beat_q;
        beat_q  <= last_beat ? '0 : beat_q + 1'b1;
      end else if (done) begin
        beat_q <= '0;
      end
    end
  end

  neuron_wmem #(
    .NUM_WEIGHT (NUM_WEIGHT),
    .DATA_WIDTH (DW),
    .LANES      (LANES)
  ) u_wmem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (weight_valid & cfg_match & (state_q == IDLE)),
    .wr_dat  (weight_value[DW-1:0]),
    .rd_beat (s0_beat),
    .rd_row  (row)
  );

  // Data stages carry no reset; the valid bits above qualify them.
  always_ff @(posedge clk) begin
    if (accept) s0_dat <= in_data;
    s1_dat <= s0_dat;
    for (int k = 0; k < LANES; k++) begin
      prod[k] <= AW'($signed(s1_dat[k*DW +: DW])) * AW'($signed(row[k*DW +: DW]));
    end
  end

  always_comb begin
    tree = '0;
    for (int k = 0; k < LANES; k++) tree = tree + TW'(prod[k]);
  end

  assign bias_term = {bias_q, {DW{1'b0}}};
  assign acc_add   = s2_vld ? 64'(tree) : 64'(bias_term);
  assign acc_sum   = sat_add(64'(acc_q), acc_add, AW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (done) begin
      acc_q <= '0;
    end else if (s2_vld || state_q == BIAS) begin
      acc_q <= acc_sum[AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         bias_q <= '0;
    else if (bias_valid && cfg_match) bias_q <= bias_value[DW-1:0];
  end

  assign act_u       = acc_q[AW-1 -: WI];
  assign act_f       = acc_q[AW-1-WI -: DW];
  assign act_sign_ok = (&{act_u, act_f[DW-1]}) | ~(|{act_u, act_f[DW-1]});

  always_comb begin
    act_res = act_f;
    if (act_mode == ACT_RELU) begin
      if (acc_q[AW-1])  act_res = '0;
      else if (|act_u)  act_res = '1;
    end else if (!act_sign_ok) begin
      act_res = acc_q[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state_q == ACT) begin
      out_valid <= 1'b1;
      out_data  <= act_res;
    end else if (done) begin
      out_valid <= 1'b0;
    end
  end

  assign unused_bits = &{1'b0, weight_value[31:DW], bias_value[31:DW], acc_sum[63:AW]};

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Directed plus randomized bench for neuron_mac_lanes (LANES=4, NUM_WEIGHT=6)
// against an arithmetic reference model of the neuron.
module tb_neuron_mac_lanes;

  localparam int DW = 16;
  localparam int LANES = 4;
  localparam int NW = 6;
  localparam int NB = 2;

  logic                 clk, rst;
  logic [LANES*DW-1:0]  in_data;
  logic                 in_valid, in_ready;
  logic                 weight_valid, bias_valid;
  logic [31:0]          weight_value, bias_value;
  logic [31:0]          config_layer_num, config_neuron_num;
  logic                 act_mode;
  logic [DW-1:0]        out_data;
  logic                 out_valid, out_ready, busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] w_m [NW];
  logic [15:0] x_m [NB*LANES];
  logic [15:0] b_m;

  neuron_mac_lanes #(
    .LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_WIDTH(DW),
    .LANES(LANES), .WEIGHT_INT_WIDTH(1)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .act_mode(act_mode), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Dot product over the first NW inputs, clamped after every beat and after the bias,
  // then the output field is acc / 2^15 clamped to the mode's range.
  function automatic logic [15:0] model_out(input bit mode);
    longint acc, s, v;
    int i;
    acc = 0;
    for (int b = 0; b < NB; b++) begin
      s = 0;
      for (int k = 0; k < LANES; k++) begin
        i = b * LANES + k;
        if (i < NW) s += longint'($signed(x_m[i])) * longint'($signed(w_m[i]));
      end
      acc = clamp32(acc + s);
    end
    acc = clamp32(acc + longint'($signed(b_m)) * 65536);
    if (!mode) begin
      if (acc < 0) v = 0;
      else v = acc / 32768;
      if (v > 65535) v = 65535;
    end else begin
      v = acc >>> 15;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
    end
    return v[15:0];
  endfunction

  task automatic wr_weight(input logic [15:0] v);
    weight_valid = 1'b1;
    weight_value = {16'h0, v};
    @(negedge clk);
    weight_valid = 1'b0;
  endtask

  task automatic load_w();
    for (int i = 0; i < NW; i++) wr_weight(w_m[i]);
  endtask

  task automatic wr_bias(input logic [15:0] v, input logic [31:0] nrn);
    bias_valid        = 1'b1;
    bias_value        = {16'h0, v};
    config_neuron_num = nrn;
    @(negedge clk);
    bias_valid        = 1'b0;
    config_neuron_num = 32'd0;
  endtask

  task automatic send_beats();
    int n;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < LANES; k++) in_data[k*DW +: DW] = x_m[b*LANES+k];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("beat_accept", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_vld", 32'(out_valid), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_rdy", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input bit mode);
    int lat;
    act_mode = mode;
    send_beats();
    wait_out(lat);
    check({tag, "_lat"}, 32'(lat), 32'd6);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    check({tag, "_dat"}, 32'(out_data), 32'(model_out(mode)));
    release_out();
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b0;
    in_data = '0; in_valid = 1'b0;
    weight_valid = 1'b0; weight_value = '0;
    bias_valid = 1'b0; bias_value = '0;
    config_layer_num = 32'd1; config_neuron_num = 32'd0;
    act_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_inrdy", 32'(in_ready), 32'd1);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_dat", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Test 1: masked tail lanes driven with 0x7FFF
    foreach (w_m[i]) w_m[i] = 16'h4000;
    for (int i = 0; i < NB*LANES; i++) x_m[i] = (i < NW) ? 16'h4000 : 16'h7FFF;
    b_m = 16'h0;
    load_w();
    wr_bias(b_m, 32'd0);
    run("t1_relu", 1'b0);
    run("t1_lin", 1'b1);

    // Test 2: negative inputs
    for (int i = 0; i < NW; i++) x_m[i] = 16'hC000;
    run("t2_relu", 1'b0);
    run("t2_lin", 1'b1);

    // Test 3: accumulator clamp
    foreach (w_m[i]) w_m[i] = 16'h7FFF;
    for (int i = 0; i < NW; i++) x_m[i] = 16'h7FFF;
    load_w();
    run("t3_relu", 1'b0);
    run("t3_lin", 1'b1);

    // Test 4: bias only, then a bias write aimed at another neuron
    foreach (w_m[i]) w_m[i] = 16'h0000;
    load_w();
    b_m = 16'h0100;
    wr_bias(b_m, 32'd0);
    run("t4_bias", 1'b0);
    wr_bias(16'h0300, 32'd1);
    run("t4_ignore", 1'b0);

    // Test 5: output back-pressure, then early out_ready
    foreach (w_m[i]) w_m[i] = 16'h4000;
    load_w();
    b_m = 16'h0;
    wr_bias(b_m, 32'd0);
    for (int i = 0; i < NB*LANES; i++) x_m[i] = 16'($urandom);
    act_mode = 1'b1;
    send_beats();
    wait_out(lat);
    check("t5_lat", 32'(lat), 32'd6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_hold_vld", 32'(out_valid), 32'd1);
      check("t5_hold_dat", 32'(out_data), 32'(model_out(1'b1)));
      check("t5_hold_inrdy", 32'(in_ready), 32'd0);
    end
    release_out();
    for (int i = 0; i < NB*LANES; i++) x_m[i] = 16'($urandom);
    act_mode = 1'b0;
    out_ready = 1'b1;
    send_beats();
    wait_out(lat);
    check("t5e_lat", 32'(lat), 32'd6);
    check("t5e_dat", 32'(out_data), 32'(model_out(1'b0)));
    @(negedge clk);
    check("t5e_vld_drop", 32'(out_valid), 32'd0);
    check("t5e_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // Test 6: reset during DRAIN, weights retained, busy weight writes ignored
    for (int i = 0; i < NB*LANES; i++) x_m[i] = (i < NW) ? 16'h4000 : 16'h7FFF;
    act_mode = 1'b0;
    send_beats();
    rst = 1'b0;
    #1;
    check("t6_rst_vld", 32'(out_valid), 32'd0);
    check("t6_rst_inrdy", 32'(in_ready), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t6_no_out", 32'(seen), 32'd0);
    run("t6_rerun", 1'b0);
    send_beats();
    for (int i = 0; i < NW; i++) wr_weight(16'h0000);
    wait_out(lat);
    check("t6_busy_vld", 32'(out_valid), 32'd1);
    check("t6_busy_dat", 32'(out_data), 32'(model_out(1'b0)));
    release_out();
    run("t6_after", 1'b0);

    // Randomized vectors
    for (int r = 0; r < 24; r++) begin
      foreach (w_m[i]) w_m[i] = 16'($urandom);
      for (int i = 0; i < NB*LANES; i++) x_m[i] = 16'($urandom);
      b_m = 16'($urandom);
      load_w();
      wr_bias(b_m, 32'd0);
      run($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neuron_mac_lanes.md
Name: neuron_mac_lanes

Overview:
Next-generation fully-connected neuron. It consumes LANES inputs per beat against an internally stored weight vector and accumulates the products with saturation. It then adds a loadable bias, applies a run-time-selected activation (ReLU or signed linear), and presents the result on a valid/ready output. It sits in a layer in place of the single-lane neuron, shares the config_layer_num/config_neuron_num weight-loading bus, and adds input back-pressure.

Parameters:
LAYER_NO, 1, layer index matched against config_layer_num
NEURON_NO, 0, neuron index matched against config_neuron_num
NUM_WEIGHT, 784, weights per neuron (any value ≥1)
DATA_WIDTH, 16, signed fixed-point width of inputs, weights, bias and output
LANES, 4, inputs/products per beat (power of 2, ≥1)
WEIGHT_INT_WIDTH, 1, integer bits used to select the output field

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-low
in_data  in  LANES*DATA_WIDTH  lane k at bits [k*DW +: DW]
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
weight_valid  in  1  weight write strobe
weight_value  in  32  weight in [DW-1:0]
bias_valid  in  1  bias write strobe
bias_value  in  32  bias in [DW-1:0]
config_layer_num  in  32  target layer for weight/bias writes
config_neuron_num  in  32  target neuron for weight/bias writes
act_mode  in  1  0 = ReLU, 1 = signed linear; sampled in ACT
out_data  out  DATA_WIDTH  activation result
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; in_ready=1, out_valid=0, out_data=0, busy=0.
  - Write pointer, beat counter, accumulator and bias register clear to 0.
  - Weight array contents are not reset.
- Weight load (only while IDLE):
  - Write occurs when weight_valid & layer/neuron match. The weight is stored at the pointer, and the pointer increments.
  - The pointer wraps from NUM_WEIGHT-1 to 0.
  - Writes while busy or with a mismatched config are ignored.
- Bias load:
  - Bias is loaded when bias_valid & match, in any state.
  - The value in the register is the one sampled in BIAS.
- BEATS = ceil(NUM_WEIGHT/LANES).
  - Beat b uses weights b*LANES .. b*LANES+LANES-1.
  - Lanes with index ≥ NUM_WEIGHT in the last beat contribute 0.
- Pipeline per beat:
  - t: accept.
  - t+1: weight row registered.
  - t+2: LANES signed products of 2*DW bits registered.
  - t+3: adder tree (width 2*DW+clog2(LANES)) plus accumulator, computed wide and clamped to the signed 2*DW range [0x8000..0, 0x7FFF..F].
- FSM states:
  - IDLE: in_ready=1. First accepted beat goes to ACCUM.
  - ACCUM: in_ready=1. When beat BEATS-1 is accepted, go to DRAIN (in_ready drops the next cycle). If BEATS=1, the first beat goes directly IDLE→DRAIN.
  - DRAIN: in_ready=0. Wait until the last beat has accumulated (3 cycles after its accept), then go to BIAS.
  - BIAS: acc ← sat(acc + {bias[DW-1:0], DW'b0}). One cycle.
  - ACT: compute the output, register out_data, set out_valid. One cycle.
  - OUT: hold out_data and out_valid until out_ready, then go to IDLE with acc=0 and beat counter=0.
- Activation, with field F = acc[2DW-1-WEIGHT_INT_WIDTH -: DW] and upper bits U = acc[2DW-1 : 2DW-WEIGHT_INT_WIDTH]:
  - ReLU: acc<0 → 0. U≠0 → all-ones (unsigned saturation). Otherwise F.
  - Linear: if U and F's MSB are all equal → F. Otherwise saturate to 0x7FFF (acc≥0) or 0x8000 (acc<0).
- Timing: the ACT result is visible with out_valid=1 at cycle t_last+6. out_valid is never high with in_ready=1.
- Boundaries:
  - A beat offered with in_valid while in_ready=0 is not consumed.
  - out_ready may be high early; the handshake completes on the first cycle with out_valid high.
  - Reset mid-operation abandons the partial sum; no out_valid is produced.

Decomposition:
- Package neuron_pkg:
  - state enum {IDLE, ACCUM, DRAIN, BIAS, ACT, OUT}
  - act_mode constants ACT_RELU=0, ACT_LINEAR=1
  - function sat_add(a, b, width)
  - localparam-helper for BEATS
- Sub-module neuron_wmem:
  - NUM_WEIGHT entries, sequential single-weight write port.
  - Synchronous LANES-wide row read addressed by beat index, with out-of-range lanes masked to 0.

Test Plan:
1. LANES=4, NUM_WEIGHT=6; all weights 0x4000, inputs 0x4000, bias 0, ReLU → acc 0x60000000, out_data 0xC000. Same run in linear mode → 0x7FFF. Last-beat lanes 2,3 are masked (drive them with 0x7FFF; result is unchanged).
2. Inputs 0xC000, weights 0x4000 → acc 0xA0000000. ReLU → 0x0000; linear → 0x8000.
3. Weights and inputs 0x7FFF → accumulator clamps to 0x7FFFFFFF. ReLU → 0xFFFF; linear → 0x7FFF.
4. Weights 0, bias 0x0100 → acc 0x01000000, ReLU out 0x0200. A bias write with mismatched neuron number is ignored (out stays 0x0200).
5. Hold out_ready low 5 cycles → out_valid/out_data stable, in_ready=0. Release → IDLE, and the next vector's result is independent of the prior one. out_valid rises exactly 6 cycles after the last beat handshake.
6. Assert rst low during DRAIN → out_valid=0, in_ready=1 immediately. Rerun test 1 → 0xC000 (weights retained). Weight writes issued while busy are ignored.
